// File: rtl/nn_pkg.sv
// Shared types and default sizing for the neural-network output stage.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } mf_state_e;

  localparam int NEURONS     = 10;
  localparam int DATA_WIDTH  = 16;
  localparam int INDEX_WIDTH = 4;

endpackage

// File: rtl/max_finder_if.sv
// Handshake bundle for max_finder: score vector in, winning index out.
// Carries max_out_value only when MAX_FINDER_VALUE_OUT_EN is defined.
interface max_finder_if
  import nn_pkg::*;
#(
  parameter int neurons    = NEURONS,
  parameter int dataWidth  = DATA_WIDTH,
  parameter int indexWidth = INDEX_WIDTH
);

  logic                         max_in_valid;
  logic [neurons*dataWidth-1:0] max_in_data;
  logic                         max_out_valid;
  logic [indexWidth-1:0]        max_out_index;
  logic                         max_busy;
`ifdef MAX_FINDER_VALUE_OUT_EN
  logic [dataWidth-1:0]         max_out_value;
`endif

  modport master (
    output max_in_valid, max_in_data,
`ifdef MAX_FINDER_VALUE_OUT_EN
    input  max_out_value,
`endif
    input  max_out_valid, max_out_index, max_busy
  );

  modport slave (
    input  max_in_valid, max_in_data,
`ifdef MAX_FINDER_VALUE_OUT_EN
    output max_out_value,
`endif
    output max_out_valid, max_out_index, max_busy
  );

endinterface

// File: rtl/max_finder.sv
// Sequential arg-max over a captured score vector, one element per cycle.
// Optional winning-score output enabled by MAX_FINDER_VALUE_OUT_EN.
module max_finder
  import nn_pkg::*;
#(
  parameter int neurons    = NEURONS,
  parameter int dataWidth  = DATA_WIDTH,
  parameter int indexWidth = INDEX_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  max_finder_if.slave  bus
);

  localparam int             CW       = $clog2(neurons) + 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(neurons - 1);

  mf_state_e                    state_q, state_d;
  logic [neurons*dataWidth-1:0] buf_q;
  logic [CW-1:0]                cnt_q;
  logic [dataWidth-1:0]         run_max_q;
  logic [indexWidth-1:0]        run_idx_q;
  logic                         out_valid_q;
  logic [indexWidth-1:0]        out_idx_q;
  logic [dataWidth-1:0]         cur_s;
`ifdef MAX_FINDER_VALUE_OUT_EN
  logic [dataWidth-1:0]         out_val_q;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state; inputs seen outside IDLE are ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.max_in_valid) begin
          state_d = (neurons == 1) ? DONE : SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d = SCAN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Element under comparison; counter values past the end read as zero
  always_comb begin
    cur_s = '0;
    for (int i = 0; i < neurons; i++) begin
      cur_s = (cnt_q == CW'(i)) ? buf_q[i*dataWidth +: dataWidth] : cur_s;
    end
  end

  // Capture, compare/update and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
`ifdef MAX_FINDER_VALUE_OUT_EN
      out_val_q   <= '0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.max_in_valid) begin
            buf_q     <= bus.max_in_data;
            run_max_q <= bus.max_in_data[dataWidth-1:0];
            run_idx_q <= '0;
            cnt_q     <= CW'(1);
          end
        end
        SCAN: begin
          // strict compare keeps the lowest index on ties
          if (cur_s > run_max_q) begin
            run_max_q <= cur_s;
            run_idx_q <= indexWidth'(cnt_q);
          end
          cnt_q <= cnt_q + CW'(1);
        end
        DONE: begin
          out_valid_q <= 1'b1;
          out_idx_q   <= run_idx_q;
`ifdef MAX_FINDER_VALUE_OUT_EN
          out_val_q   <= run_max_q;
`endif
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.max_out_valid = out_valid_q;
  assign bus.max_out_index = out_idx_q;
  assign bus.max_busy      = (state_q != IDLE);
`ifdef MAX_FINDER_VALUE_OUT_EN
  assign bus.max_out_value = out_val_q;
`endif

endmodule
